// File: rtl/ifu_pkg.sv
// ifu_pkg: shared encodings and defaults for the instruction-fetch controller.
package ifu_pkg;
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
endpackage

// File: rtl/ifu_npc_calc.sv
// ifu_npc_calc: next-PC mux, redirect targets and illegal-PC flag.
// IFU_BOUNDS_CHECK_EN adds a ROM range check to the misalignment check.
module ifu_npc_calc import ifu_pkg::*; #(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter int          IM_ADDR_W = 10
) (
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic        valid_d,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] npc,
    output logic        bad
);
    logic [31:0] seq, pc_d4, br_tgt, j_tgt;
    always_comb begin
        seq    = pc_f + 32'd4;
        pc_d4  = pc_d + 32'd4;
        br_tgt = pc_d4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_tgt  = {pc_d4[31:28], imm26, 2'b00};
        // redirects come from the D stage, so only a real IF/ID instruction may steer
        npc = !valid_d               ? seq :
              npc_sel == NPC_BR      ? (br_taken ? br_tgt : seq) :
              npc_sel == NPC_J       ? j_tgt :
              npc_sel == NPC_JR      ? rs_val : seq;
    end
`ifdef IFU_BOUNDS_CHECK_EN
    localparam logic [31:0] PC_END = PC_RESET + (32'd4 << IM_ADDR_W);
    assign bad = (|npc[1:0]) || (npc < PC_RESET) || (npc >= PC_END);
`else
    assign bad = |npc[1:0];
`endif
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch PC, IF/ID register and BOOT/RUN/HALT sequencing of the instruction ROM.
// Optional IFU_BOUNDS_CHECK_EN also faults on next-PCs outside the ROM window.
module ifu_fetch_ctrl import ifu_pkg::*; #(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter int          IM_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [1:0]           npc_sel,
    input  logic                 br_taken,
    input  logic [15:0]          imm16,
    input  logic [25:0]          imm26,
    input  logic [31:0]          rs_val,
    output logic [IM_ADDR_W-1:0] im_raddr,
    input  logic [31:0]          im_rdata,
    output logic [31:0]          pc_f,
    output logic [31:0]          pc_d,
    output logic [31:0]          instr_d,
    output logic                 instr_valid_d,
    output logic                 fault
);
    state_t      state;
    logic [31:0] npc;
    logic        bad;

    assign im_raddr = IM_ADDR_W'((pc_f - PC_RESET) >> 2);

    ifu_npc_calc #(.PC_RESET(PC_RESET), .IM_ADDR_W(IM_ADDR_W)) u_npc (
        .pc_f(pc_f), .pc_d(pc_d), .valid_d(instr_valid_d), .npc_sel(npc_sel),
        .br_taken(br_taken), .imm16(imm16), .imm26(imm26), .rs_val(rs_val),
        .npc(npc), .bad(bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_BOOT;
            pc_f          <= PC_RESET;
            pc_d          <= '0;
            instr_d       <= '0;
            instr_valid_d <= 1'b0;
            fault         <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    pc_d          <= pc_f;
                    instr_d       <= im_rdata;
                    instr_valid_d <= 1'b1;
                    pc_f          <= pc_f + 32'd4;
                    state         <= S_RUN;
                end
                S_RUN: if (!stall) begin
                    // an illegal target freezes fetch at the last legal PC
                    if (bad) begin
                        state         <= S_HALT;
                        fault         <= 1'b1;
                        instr_valid_d <= 1'b0;
                    end else begin
                        pc_d          <= pc_f;
                        instr_d       <= im_rdata;
                        instr_valid_d <= 1'b1;
                        pc_f          <= npc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed bench for ifu_fetch_ctrl with a combinational ROM model.
module tb_ifu_fetch_ctrl;
    import ifu_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_sel = NPC_SEQ;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] rs_val = '0;
    logic [9:0]  im_raddr;
    logic [31:0] im_rdata, pc_f, pc_d, instr_d;
    logic        instr_valid_d, fault;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [9:0] a);
        return 32'hA000_0000 + {22'd0, a};
    endfunction
    assign im_rdata = rom(im_raddr);

    ifu_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc_sel(npc_sel), .br_taken(br_taken),
        .imm16(imm16), .imm26(imm26), .rs_val(rs_val), .im_raddr(im_raddr),
        .im_rdata(im_rdata), .pc_f(pc_f), .pc_d(pc_d), .instr_d(instr_d),
        .instr_valid_d(instr_valid_d), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pcf"}, pc_f, 32'h3000);
        chk({tag, "_pcd"}, pc_d, 32'h0);
        chk({tag, "_instr"}, instr_d, 32'h0);
        chk({tag, "_valid"}, {31'd0, instr_valid_d}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_raddr"}, {22'd0, im_raddr}, 32'd0);
    endtask

    initial begin
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        stall = 1'b1;
        tick();
        chk("boot_pcd", pc_d, 32'h3000);
        chk("boot_instr", instr_d, rom(10'd0));
        chk("boot_pcf", pc_f, 32'h3004);
        chk("boot_valid", {31'd0, instr_valid_d}, 32'd1);
        stall = 1'b0;
        tick();
        tick();
        chk("seq_instr", instr_d, rom(10'd2));
        chk("seq_pcd", pc_d, 32'h3008);
        chk("seq_raddr", {22'd0, im_raddr}, 32'd3);
        npc_sel = NPC_BR; br_taken = 1'b1; imm16 = 16'hFFFE;
        tick();
        chk("br_slot_pcd", pc_d, 32'h300C);
        chk("br_slot_instr", instr_d, rom(10'd3));
        chk("br_pcf", pc_f, 32'h3004);
        npc_sel = NPC_SEQ; br_taken = 1'b0;
        tick();
        chk("br_tgt_instr", instr_d, rom(10'd1));
        chk("br_tgt_pcf", pc_f, 32'h3008);
        npc_sel = NPC_JR; rs_val = 32'h3010; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pcf", pc_f, 32'h3008);
            chk("stall_instr", instr_d, rom(10'd1));
            chk("stall_pcd", pc_d, 32'h3004);
        end
        stall = 1'b0;
        tick();
        chk("jr_pcf", pc_f, 32'h3010);
        chk("jr_slot_instr", instr_d, rom(10'd2));
        npc_sel = NPC_JR; rs_val = 32'h3012;
        tick();
        chk("flt_fault", {31'd0, fault}, 32'd1);
        chk("flt_valid", {31'd0, instr_valid_d}, 32'd0);
        chk("flt_pcf", pc_f, 32'h3010);
        npc_sel = NPC_SEQ;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            tick();
            chk("halt_fault", {31'd0, fault}, 32'd1);
            chk("halt_valid", {31'd0, instr_valid_d}, 32'd0);
            chk("halt_pcf", pc_f, 32'h3010);
            chk("halt_instr", instr_d, rom(10'd2));
            chk("halt_raddr", {22'd0, im_raddr}, 32'd4);
        end
        stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async");
        #3 rst_n = 1'b1;
        tick();
        chk("reboot_pcd", pc_d, 32'h3000);
        chk("reboot_instr", instr_d, rom(10'd0));
        chk("reboot_pcf", pc_f, 32'h3004);
        chk("reboot_valid", {31'd0, instr_valid_d}, 32'd1);
        npc_sel = NPC_J; imm26 = 26'h0001000;
        tick();
`ifdef IFU_BOUNDS_CHECK_EN
        chk("j_fault", {31'd0, fault}, 32'd1);
        chk("j_pcf", pc_f, 32'h3004);
`else
        chk("j_fault", {31'd0, fault}, 32'd0);
        chk("j_pcf", pc_f, 32'h4000);
        chk("j_raddr", {22'd0, im_raddr}, 32'd0);
        chk("j_pcd", pc_d, 32'h3004);
`endif
        npc_sel = NPC_SEQ;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
